// File: rtl/fp_pkg.sv
// Shared constants and helpers for the floating-point adder significand datapath.
// This block only implements round-to-nearest-even.
package fp_pkg;

   localparam int MANT_W_DEF = 10;
   localparam int GRS_W      = 3;

   typedef enum logic {RM_RNE = 1'b0} round_mode_t;
   localparam round_mode_t ROUND_MODE = RM_RNE;

   // Width of the signed exponent correction. It must hold -(MANT_W+3) .. +2.
   function automatic int eadj_w(input int mant_w);
      return $clog2(mant_w + GRS_W) + 1;
   endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter. The count is W when the input is all zeros.
module fp_lzc #(
   parameter int W  = 14,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  d,
   output logic [CW-1:0] cnt
);

   always_comb begin
      cnt = CW'(W);
      // The scan runs from the LSB upward, so the highest set bit is the last one to write cnt.
      for (int unsigned i = 0; i < W; i++) begin
         if (d[i]) cnt = CW'(W - 1 - i);
      end
   end

endmodule

// File: rtl/mantissa_align_add.sv
// This is a two-stage significand datapath. Stage 1 aligns B to A using a sticky bit.
// Stage 2 adds or subtracts, normalizes, and rounds to nearest-even.
module mantissa_align_add
   import fp_pkg::*;
#(
   parameter int MANT_W  = MANT_W_DEF,
   parameter int SHIFT_W = 5
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [SHIFT_W-1:0]                in_shift,
   input  logic [MANT_W-1:0]                 in_a_frac,
   input  logic [MANT_W-1:0]                 in_b_frac,
   input  logic                              in_sub,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [MANT_W-1:0]                 out_frac,
   output logic signed [eadj_w(MANT_W)-1:0]  out_exp_adj,
   output logic                              out_swap,
   output logic                              out_zero,
   output logic                              out_inexact
);

   localparam int EADJ_W = eadj_w(MANT_W);
   localparam int XW     = MANT_W + 1 + GRS_W;
   localparam int LZW    = $clog2(XW + 1);

   logic en;
   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   logic [XW-1:0] sa_ext, sb_ext, sb_shr, sb_al;
   logic          lost;

   // The hidden bit is always set. A shift of XW or more therefore leaves zero and sets sticky with no special case.
   always_comb begin
      sa_ext = {1'b1, in_a_frac, {GRS_W{1'b0}}};
      sb_ext = {1'b1, in_b_frac, {GRS_W{1'b0}}};
      lost   = 1'b0;
      for (int unsigned i = 0; i < XW; i++) begin
         if (i < 32'(in_shift)) lost = lost | sb_ext[i];
      end
      sb_shr = sb_ext >> in_shift;
      sb_al  = {sb_shr[XW-1:1], sb_shr[0] | lost};
   end

   logic          s1_valid, s1_sub;
   logic [XW-1:0] s1_a, s1_b;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sub   <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
      end else if (en) begin
         s1_valid <= in_valid;
         s1_sub   <= in_sub;
         s1_a     <= sa_ext;
         s1_b     <= sb_al;
      end
   end

   logic [XW:0]              sum;
   logic [XW-1:0]            diff, m;
   logic [LZW-1:0]           lz;
   logic                     b_gt_a, g, r, s, lsb, round_up, ovf;
   logic                     zero_n, swap_n, inex_n;
   logic [MANT_W-1:0]        frac_n;
   logic signed [EADJ_W-1:0] adj_norm, adj_n;

   fp_lzc #(.W(XW), .CW(LZW)) u_lzc (.d(diff), .cnt(lz));

   always_comb begin
      sum    = {1'b0, s1_a} + {1'b0, s1_b};
      b_gt_a = s1_a < s1_b;
      diff   = b_gt_a ? s1_b - s1_a : s1_a - s1_b;
      swap_n = s1_sub && b_gt_a;
      if (s1_sub) begin
         m        = diff << lz;
         adj_norm = EADJ_W'(0) - EADJ_W'(lz);
      end else if (sum[XW]) begin
         m        = {sum[XW:2], sum[1] | sum[0]};
         adj_norm = EADJ_W'(1);
      end else begin
         m        = sum[XW-1:0];
         adj_norm = '0;
      end
      // After normalization the hidden bit is clear only when the difference was exactly zero.
      zero_n   = !m[XW-1];
      lsb      = m[GRS_W];
      g        = m[GRS_W-1];
      r        = m[GRS_W-2];
      s        = m[GRS_W-3];
      round_up = (ROUND_MODE == RM_RNE) && g && (r || s || lsb);
      ovf      = round_up && (&m[XW-2:GRS_W]);
      frac_n   = m[XW-2:GRS_W] + MANT_W'(round_up);
      adj_n    = ovf ? adj_norm + EADJ_W'(1) : adj_norm;
      inex_n   = g || r || s;
      if (zero_n) adj_n = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_frac    <= '0;
         out_exp_adj <= '0;
         out_swap    <= 1'b0;
         out_zero    <= 1'b0;
         out_inexact <= 1'b0;
      end else if (en) begin
         out_valid   <= s1_valid;
         out_frac    <= frac_n;
         out_exp_adj <= adj_n;
         out_swap    <= swap_n;
         out_zero    <= zero_n;
         out_inexact <= inex_n;
      end
   end

endmodule

// File: tb/tb_mantissa_align_add.sv
// Scoreboard bench for mantissa_align_add with MANT_W=10. It covers directed vectors, stall handling and reset mid-stream.
module tb_mantissa_align_add;

   typedef struct packed {
      logic [9:0]        frac;
      logic signed [4:0] adj;
      logic              swap;
      logic              zero;
      logic              inexact;
   } res_t;

   logic              clk = 1'b0;
   logic              rst, in_valid, in_ready, in_sub, out_valid, out_ready;
   logic [4:0]        in_shift;
   logic [9:0]        in_a_frac, in_b_frac, out_frac;
   logic signed [4:0] out_exp_adj;
   logic              out_swap, out_zero, out_inexact;

   int   checks = 0;
   int   errors = 0;
   res_t q[$];
   res_t obs_now;

   always #5 clk = ~clk;

   mantissa_align_add #(.MANT_W(10), .SHIFT_W(5)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_shift(in_shift), .in_a_frac(in_a_frac), .in_b_frac(in_b_frac), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready), .out_frac(out_frac),
      .out_exp_adj(out_exp_adj), .out_swap(out_swap), .out_zero(out_zero),
      .out_inexact(out_inexact)
   );

   assign obs_now = '{out_frac, out_exp_adj, out_swap, out_zero, out_inexact};

   function automatic res_t mk(input logic [9:0] f, input int adj, input logic sw,
                               input logic z, input logic ix);
      return '{f, 5'(adj), sw, z, ix};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Pop and compare results at the falling edge, when a handshake is about to happen.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            check("unexpected_result", 32'(obs_now), 32'h3FFFF + 1);
         end else begin
            check("result", 32'(obs_now), 32'(q[0]));
            void'(q.pop_front());
         end
      end
   end

   task automatic drive(input int sh, input logic [9:0] a, input logic [9:0] b, input logic sub);
      in_valid  = 1'b1;
      in_shift  = 5'(sh);
      in_a_frac = a;
      in_b_frac = b;
      in_sub    = sub;
   endtask

   task automatic send(input int sh, input logic [9:0] a, input logic [9:0] b,
                       input logic sub, input res_t e);
      bit acc = 0;
      drive(sh, a, b, sub);
      for (int i = 0; i < 50 && !acc; i++) begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back(e);
            acc = 1;
         end
         @(posedge clk);
         #1;
      end
      if (!acc) begin
         checks++;
         errors++;
         $error("FAIL send_timeout: observed=in_ready_low expected=accept");
      end
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      #1;
      check("drain_empty", 32'(q.size()), 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_shift = '0; in_a_frac = '0; in_b_frac = '0; in_sub = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(obs_now), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      @(posedge clk); #1;

      // These are directed vectors with expected results worked out by hand.
      send(0,  10'h000, 10'h000, 1'b0, mk(10'h000,  1, 0, 0, 0));
      send(1,  10'h000, 10'h001, 1'b0, mk(10'h200,  0, 0, 0, 1));
      send(11, 10'h3FF, 10'h3FF, 1'b0, mk(10'h000,  1, 0, 0, 1));
      send(0,  10'h200, 10'h100, 1'b1, mk(10'h000, -2, 0, 0, 0));
      send(0,  10'h100, 10'h200, 1'b1, mk(10'h000, -2, 1, 0, 0));
      send(0,  10'h155, 10'h155, 1'b1, mk(10'h000,  0, 0, 1, 0));
      send(20, 10'h3FF, 10'h000, 1'b0, mk(10'h3FF,  0, 0, 0, 1));
      send(0,  10'h001, 10'h000, 1'b0, mk(10'h000,  1, 0, 0, 1));
      send(0,  10'h003, 10'h000, 1'b0, mk(10'h002,  1, 0, 0, 1));
      send(1,  10'h000, 10'h000, 1'b1, mk(10'h000, -1, 0, 0, 0));
      send(2,  10'h000, 10'h001, 1'b1, mk(10'h200, -1, 0, 0, 1));
      drain();

      // Back-to-back beats with a 3-cycle downstream stall.
      send(0, 10'h000, 10'h000, 1'b0, mk(10'h000, 1, 0, 0, 0));
      send(1, 10'h000, 10'h001, 1'b0, mk(10'h200, 0, 0, 0, 1));
      drive(11, 10'h3FF, 10'h3FF, 1'b0);
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall_in_ready", 32'(in_ready), 0);
         check("stall_hold", 32'({out_valid, obs_now}), 32'({1'b1, mk(10'h000, 1, 0, 0, 0)}));
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      send(11, 10'h3FF, 10'h3FF, 1'b0, mk(10'h000, 1, 0, 0, 1));
      send(20, 10'h3FF, 10'h000, 1'b0, mk(10'h3FF, 0, 0, 0, 1));
      drain();

      // Reset during a stall drops all beats that are still in flight.
      send(0, 10'h001, 10'h000, 1'b0, mk(10'h000, 1, 0, 0, 1));
      send(0, 10'h003, 10'h000, 1'b0, mk(10'h002, 1, 0, 0, 1));
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      q.delete();
      @(posedge clk); #1;
      check("midrst_out_valid", 32'(out_valid), 0);
      check("midrst_in_ready", 32'(in_ready), 1);
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         check("post_rst_idle", 32'(out_valid), 0);
      end
      send(1, 10'h000, 10'h000, 1'b1, mk(10'h000, -1, 0, 0, 0));
      send(2, 10'h000, 10'h001, 1'b1, mk(10'h200, -1, 0, 0, 1));
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
